// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life generation sequencer.
// Optional RESEED behaviour in the top level is enabled by defining GOL_RESEED_EN.
package gol_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam int ROW_W  = $clog2(GRID_H);

    typedef logic [GRID_W-1:0]             row_t;
    typedef logic [GRID_H-1:0][GRID_W-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2,
        RESEED  = 2'd3
    } state_t;

    // Glider in the top-left corner: rows 0..2 = .X. / ..X / XXX (bit x = cell x)
    localparam grid_t INIT_PATTERN = {{((GRID_H-3)*GRID_W){1'b0}},
                                      16'h0007, 16'h0004, 16'h0002};

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/gol_row_rule.sv
// Combinational Game of Life rule for one row, wrapping horizontally.
// Vertical wrap is the caller's job: it picks which rows feed above/below.
module gol_row_rule
    import gol_pkg::*;
(
    input  logic [GRID_W-1:0] i_above,
    input  logic [GRID_W-1:0] i_cur,
    input  logic [GRID_W-1:0] i_below,
    output logic [GRID_W-1:0] o_next
);

    for (genvar x = 0; x < GRID_W; x++) begin : g_cell
        localparam int XL = (x + GRID_W - 1) % GRID_W;
        localparam int XR = (x + 1) % GRID_W;

        logic [3:0] w_cnt;

        // Sum of the 8 neighbours; max 8 fits in 4 bits
        assign w_cnt = {3'b000, i_above[XL]} + {3'b000, i_above[x]} + {3'b000, i_above[XR]}
                     + {3'b000, i_cur[XL]}                          + {3'b000, i_cur[XR]}
                     + {3'b000, i_below[XL]} + {3'b000, i_below[x]} + {3'b000, i_below[XR]};

        assign o_next[x] = (w_cnt == 4'd3) | (i_cur[x] & (w_cnt == 4'd2));
    end

endmodule

// File: rtl/gol_gen_sequencer.sv
// Game of Life grid owner and generation sequencer for the VGA demo.
// Computes the next generation row by row into a shadow buffer and commits
// it in one edge during blanking, so scanout never sees a torn frame.
// Build option: define GOL_RESEED_EN to refill an empty grid from an LFSR.
//
// state   | meaning
// IDLE    | grid stable, seed writes accepted, waiting for a request
// COMPUTE | one shadow row per cycle, GRID_H cycles
// COMMIT  | waiting for blanking to copy shadow -> grid
// RESEED  | (GOL_RESEED_EN) refilling an empty grid, one row per cycle
module gol_gen_sequencer
    import gol_pkg::*;
#(
    parameter int FRAME_DIV = 60,
    parameter int GEN_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_tick,
    input  logic              i_in_blank,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_seed_we,
    input  logic [3:0]        i_seed_row,
    input  logic [GRID_W-1:0] i_seed_data,
    output logic              o_seed_ready,
    input  logic [3:0]        i_rd_x,
    input  logic [3:0]        i_rd_y,
    output logic              o_rd_cell,
    output logic              o_busy,
    output logic [GEN_W-1:0]  o_gen_count,
    output logic              o_overrun
);

    localparam int                FC_W     = $clog2(FRAME_DIV + 1);
    localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(FRAME_DIV - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(GRID_H - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    grid_t              r_grid;
    grid_t              r_next;
    logic [ROW_W-1:0]   r_row;
    logic [FC_W-1:0]    r_frame_cnt;
    logic               r_gen_req;
    logic               r_overrun;
    logic [GEN_W-1:0]   r_gen_count;

    logic               w_frame_gen;
    logic               w_new_req;
    logic               w_start;
    logic               w_seed_wr;
    logic               w_compute;
    logic               w_commit;
    logic [ROW_W-1:0]   w_row_up;
    logic [ROW_W-1:0]   w_row_dn;
    row_t               w_rule_out;

`ifdef GOL_RESEED_EN
    logic [15:0]        r_lfsr;
    logic               w_reseed_wr;
`endif

    assign w_frame_gen = i_frame_tick & i_run & (r_frame_cnt == FC_LAST);
    assign w_new_req   = i_step | w_frame_gen;

    assign w_row_up = (r_row == '0)       ? ROW_LAST : r_row - ROW_W'(1);
    assign w_row_dn = (r_row == ROW_LAST) ? '0       : r_row + ROW_W'(1);

    gol_row_rule u_rule (
        .i_above (r_grid[w_row_up]),
        .i_cur   (r_grid[r_row]),
        .i_below (r_grid[w_row_dn]),
        .o_next  (w_rule_out)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and per-state strobes; a fresh request is taken in the same
    // cycle it arrives so busy rises one edge after the request.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_seed_wr   = 1'b0;
        w_compute   = 1'b0;
        w_commit    = 1'b0;
`ifdef GOL_RESEED_EN
        w_reseed_wr = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (i_seed_we) begin
                    w_seed_wr = 1'b1;
                end else if (r_gen_req | w_new_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                w_compute = 1'b1;
                if (r_row == ROW_LAST) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                if (i_in_blank) begin
                    w_commit = 1'b1;
`ifdef GOL_RESEED_EN
                    w_state_nxt = (r_next == '0) ? RESEED : IDLE;
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
`ifdef GOL_RESEED_EN
            RESEED: begin
                w_reseed_wr = 1'b1;
                if (r_row == ROW_LAST) w_state_nxt = IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Row pointer shared by COMPUTE and RESEED; wraps to 0 after the last row
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
        end else if (w_start) begin
            r_row <= '0;
`ifdef GOL_RESEED_EN
        end else if (w_compute | w_reseed_wr) begin
`else
        end else if (w_compute) begin
`endif
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
        end
    end

    // Frame divider: counts run-qualified frame ticks, wraps at FRAME_DIV-1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
        end else if (i_frame_tick & i_run) begin
            r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
        end
    end

    // Single pending request; anything arriving while one is held is dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gen_req <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if ((w_new_req & r_gen_req) | (i_step & w_frame_gen)) r_overrun <= 1'b1;
            r_gen_req <= w_start ? 1'b0 : (r_gen_req | w_new_req);
        end
    end

    // Shadow buffer, one row per COMPUTE cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_next        <= '0;
        else if (w_compute) r_next[r_row] <= w_rule_out;
    end

    // Committed grid: seed writes, atomic commit, and optional reseed rows
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grid <= INIT_PATTERN;
        end else if (w_seed_wr) begin
            r_grid[i_seed_row] <= i_seed_data;
        end else if (w_commit) begin
            r_grid <= r_next;
`ifdef GOL_RESEED_EN
        end else if (w_reseed_wr) begin
            r_grid[r_row] <= r_lfsr;
`endif
        end
    end

`ifdef GOL_RESEED_EN
    // LFSR runs only while reseeding so each refill continues the sequence
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         r_lfsr <= LFSR_SEED;
        else if (w_reseed_wr) r_lfsr <= lfsr_next(r_lfsr);
    end
`endif

    // Generation counter, bumped only by a commit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_gen_count <= '0;
        else if (w_commit) r_gen_count <= r_gen_count + GEN_W'(1);
    end

    assign o_rd_cell    = r_grid[i_rd_y][i_rd_x];
    assign o_busy       = (r_state != IDLE);
    assign o_seed_ready = (r_state == IDLE);
    assign o_gen_count  = r_gen_count;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Directed bench for gol_gen_sequencer with hand-computed expected grids.
module tb_gol_gen_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        in_blank = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        seed_we = 1'b0;
    logic [3:0]  seed_row = '0;
    logic [15:0] seed_data = '0;
    logic        seed_ready;
    logic [3:0]  rd_x = '0;
    logic [3:0]  rd_y = '0;
    logic        rd_cell;
    logic        busy;
    logic [15:0] gen_count;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gol_gen_sequencer #(.FRAME_DIV(3), .GEN_W(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_tick (frame_tick),
        .i_in_blank   (in_blank),
        .i_run        (run),
        .i_step       (step),
        .i_seed_we    (seed_we),
        .i_seed_row   (seed_row),
        .i_seed_data  (seed_data),
        .o_seed_ready (seed_ready),
        .i_rd_x       (rd_x),
        .i_rd_y       (rd_y),
        .o_rd_cell    (rd_cell),
        .o_busy       (busy),
        .o_gen_count  (gen_count),
        .o_overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_row(input int y, output logic [15:0] row);
        row = '0;
        for (int x = 0; x < 16; x++) begin
            rd_y = 4'(y);
            rd_x = 4'(x);
            #1;
            row[x] = rd_cell;
        end
    endtask

    task automatic chk_row(input string tag, input int y, input logic [15:0] exp);
        logic [15:0] row;
        rd_row(y, row);
        chk(tag, {16'h0, row}, {16'h0, exp});
    endtask

    task automatic seed(input int y, input logic [15:0] d);
        @(negedge clk);
        seed_we   = 1'b1;
        seed_row  = 4'(y);
        seed_data = d;
        @(negedge clk);
        seed_we   = 1'b0;
    endtask

    task automatic load_grid(input logic [15:0][15:0] g);
        for (int y = 0; y < 16; y++) seed(y, g[y]);
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_gen(input string tag, input logic [15:0] target);
        int n = 0;
        while (gen_count !== target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, {16'h0, gen_count}, {16'h0, target});
    endtask

    initial begin
        logic [15:0][15:0] g;
        logic [15:0]       row;
        logic [15:0]       acc;
        int                lat;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ready", {31'h0, seed_ready}, 32'h1);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_gen", {16'h0, gen_count}, 32'h0);
        chk_row("rst_row0", 0, 16'h0002);
        chk_row("rst_row1", 1, 16'h0004);
        chk_row("rst_row2", 2, 16'h0007);
        chk_row("rst_row3", 3, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Blinker: horizontal row 7 bits 6..8 becomes vertical column 7
        g = '0;
        g[7] = 16'h01C0;
        load_grid(g);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        chk("blink_busy", {31'h0, busy}, 32'h1);
        lat = 0;
        while (gen_count !== 16'd1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("blink_latency", lat, 17);
        chk("blink_gen", {16'h0, gen_count}, 32'h1);
        chk("blink_idle", {31'h0, busy}, 32'h0);
        chk_row("blink_r5", 5, 16'h0000);
        chk_row("blink_r6", 6, 16'h0080);
        chk_row("blink_r7", 7, 16'h0080);
        chk_row("blink_r8", 8, 16'h0080);
        chk_row("blink_r9", 9, 16'h0000);

        // Four corners form a 2x2 block across both wraps: still life
        g = '0;
        g[0]  = 16'h8001;
        g[15] = 16'h8001;
        load_grid(g);
        pulse_step();
        wait_gen("wrap_gen", 16'd2);
        chk_row("wrap_r0", 0, 16'h8001);
        chk_row("wrap_r1", 1, 16'h0000);
        chk_row("wrap_r14", 14, 16'h0000);
        chk_row("wrap_r15", 15, 16'h8001);

        // Commit hold outside blanking; seed writes ignored while busy
        g = '0;
        g[7] = 16'h01C0;
        load_grid(g);
        @(negedge clk);
        in_blank = 1'b0;
        pulse_step();
        repeat (25) @(negedge clk);
        chk("hold_busy", {31'h0, busy}, 32'h1);
        chk("hold_ready", {31'h0, seed_ready}, 32'h0);
        chk("hold_gen", {16'h0, gen_count}, 32'h2);
        chk_row("hold_r7_old", 7, 16'h01C0);
        chk_row("hold_r6_old", 6, 16'h0000);
        seed(7, 16'hFFFF);
        chk_row("busy_seed_ign", 7, 16'h01C0);
        chk("busy_seed_no_ovr", {31'h0, overrun}, 32'h0);
        @(negedge clk);
        in_blank = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_commit_gen", {16'h0, gen_count}, 32'h3);
        chk("hold_commit_idle", {31'h0, busy}, 32'h0);
        chk_row("hold_r7_new", 7, 16'h0080);
        chk_row("hold_r6_new", 6, 16'h0080);

        // Divider: ticks with run=0 are ignored, then 6 ticks at FRAME_DIV=3
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            repeat (38) @(negedge clk);
        end
        chk("div_run0_gen", {16'h0, gen_count}, 32'h3);
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulse_tick();
            repeat (38) @(negedge clk);
        end
        run = 1'b0;
        chk("div_gen", {16'h0, gen_count}, 32'h5);
        chk("div_no_ovr", {31'h0, overrun}, 32'h0);
        chk_row("div_r7", 7, 16'h0080);

        // Overrun: one request pends while busy, the next is dropped
        pulse_step();
        pulse_step();
        chk("ovr_pend_clear", {31'h0, overrun}, 32'h0);
        pulse_step();
        chk("ovr_set", {31'h0, overrun}, 32'h1);
        wait_gen("ovr_gen", 16'd7);
        repeat (40) @(negedge clk);
        chk("ovr_gen_final", {16'h0, gen_count}, 32'h7);
        chk("ovr_sticky", {31'h0, overrun}, 32'h1);

        // Reset in the middle of COMPUTE
        pulse_step();
        repeat (3) @(negedge clk);
        chk("rstmid_busy_pre", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'h0, busy}, 32'h0);
        chk("rstmid_gen", {16'h0, gen_count}, 32'h0);
        chk("rstmid_ovr", {31'h0, overrun}, 32'h0);
        chk_row("rstmid_r0", 0, 16'h0002);
        chk_row("rstmid_r2", 2, 16'h0007);
        chk_row("rstmid_r7", 7, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone cell dies: empty grid either stays empty or is reseeded
        g = '0;
        g[3] = 16'h0010;
        load_grid(g);
        pulse_step();
        wait_gen("empty_gen", 16'd1);
        repeat (20) @(negedge clk);
        chk("empty_busy", {31'h0, busy}, 32'h0);
        acc = '0;
        for (int y = 0; y < 16; y++) begin
            rd_row(y, row);
            acc = acc | row;
        end
`ifdef GOL_RESEED_EN
        chk("reseed_nonzero", {31'h0, (acc != 16'h0)}, 32'h1);
        chk_row("reseed_r0", 0, 16'hACE1);
        chk("reseed_gen", {16'h0, gen_count}, 32'h1);
`else
        chk("empty_stays", {16'h0, acc}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
